// File: rtl/rca_config_loader.sv
// rtl/rca_config_loader.sv - sequences latched RCA port addresses into the config register file
module rca_config_loader #(
  parameter int NUM_RCAS        = 3,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [$clog2(NUM_RCAS)-1:0]        cfg_rca_sel,
  input  logic [5*NUM_READ_PORTS-1:0]        cfg_src_addrs,
  input  logic [5*NUM_WRITE_PORTS-1:0]       cfg_dest_addrs,
  input  logic                               cfg_abort,
  output logic                               cfg_done,
  output logic                               cfg_err,
  output logic                               busy,
  output logic                               wr_en,
  output logic [$clog2(NUM_RCAS)-1:0]        rca_sel_w,
  output logic [$clog2(NUM_READ_PORTS)-1:0]  src_port_sel,
  output logic [$clog2(NUM_WRITE_PORTS)-1:0] dest_port_sel,
  output logic                               src_dest_port,
  output logic [4:0]                         reg_addr
);

  localparam int RW = $clog2(NUM_RCAS);
  localparam int SW = $clog2(NUM_READ_PORTS);
  localparam int DW = $clog2(NUM_WRITE_PORTS);
  localparam int CW = (SW > DW) ? SW : DW;

  localparam logic [RW:0]   RCA_LIMIT = (RW+1)'(NUM_RCAS);
  localparam logic [CW-1:0] SRC_LAST  = CW'(NUM_READ_PORTS - 1);
  localparam logic [CW-1:0] DEST_LAST = CW'(NUM_WRITE_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SRC  = 2'd1,
    S_DEST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_cnt;
  logic [5*NUM_READ_PORTS-1:0]  r_src_addrs;
  logic [5*NUM_WRITE_PORTS-1:0] r_dest_addrs;

  logic [CW-1:0] w_cnt_inc;
  logic [4:0]    w_src_next;
  logic [4:0]    w_dest_next;
  logic          w_sel_ok;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_sel_ok  = ({1'b0, cfg_rca_sel} < RCA_LIMIT);

  // Pick the latched address of the port that will be written next cycle
  always_comb begin
    w_src_next  = 5'd0;
    w_dest_next = 5'd0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (w_cnt_inc == CW'(i)) w_src_next = r_src_addrs[5*i +: 5];
    end
    for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
      if (w_cnt_inc == CW'(j)) w_dest_next = r_dest_addrs[5*j +: 5];
    end
  end

  // Load FSM; every output is registered so the write tuple lines up with the state it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_src_addrs   <= '0;
      r_dest_addrs  <= '0;
      cfg_ready     <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      busy          <= 1'b0;
      wr_en         <= 1'b0;
      rca_sel_w     <= '0;
      src_port_sel  <= '0;
      dest_port_sel <= '0;
      src_dest_port <= 1'b0;
      reg_addr      <= 5'd0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            if (w_sel_ok) begin
              // Port 0 of the source side goes out straight from the inputs being latched
              r_src_addrs   <= cfg_src_addrs;
              r_dest_addrs  <= cfg_dest_addrs;
              r_cnt         <= '0;
              r_state       <= S_SRC;
              cfg_ready     <= 1'b0;
              busy          <= 1'b1;
              wr_en         <= 1'b1;
              rca_sel_w     <= cfg_rca_sel;
              src_dest_port <= 1'b0;
              src_port_sel  <= '0;
              reg_addr      <= cfg_src_addrs[4:0];
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_SRC: begin
          if (cfg_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (r_cnt == SRC_LAST) begin
            r_state       <= S_DEST;
            r_cnt         <= '0;
            src_dest_port <= 1'b1;
            dest_port_sel <= '0;
            reg_addr      <= r_dest_addrs[4:0];
          end else begin
            r_cnt        <= w_cnt_inc;
            src_port_sel <= w_cnt_inc[SW-1:0];
            reg_addr     <= w_src_next;
          end
        end
        S_DEST: begin
          if (cfg_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (r_cnt == DEST_LAST) begin
            r_state  <= S_DONE;
            r_cnt    <= '0;
            wr_en    <= 1'b0;
            cfg_done <= 1'b1;
          end else begin
            r_cnt         <= w_cnt_inc;
            dest_port_sel <= w_cnt_inc[DW-1:0];
            reg_addr      <= w_dest_next;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          wr_en     <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_config_loader.sv
// tb/tb_rca_config_loader.sv - scoreboard bench for rca_config_loader
module tb_rca_config_loader;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_rca_sel;
  logic [9:0] cfg_src_addrs;
  logic [9:0] cfg_dest_addrs;
  logic       cfg_abort;
  logic       cfg_done;
  logic       cfg_err;
  logic       busy;
  logic       wr_en;
  logic [1:0] rca_sel_w;
  logic       src_port_sel;
  logic       dest_port_sel;
  logic       src_dest_port;
  logic [4:0] reg_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // write tuple {src_dest_port, port, rca, addr}
  logic [8:0] exp_q[$];

  rca_config_loader #(
    .NUM_RCAS(3), .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_rca_sel(cfg_rca_sel), .cfg_src_addrs(cfg_src_addrs),
    .cfg_dest_addrs(cfg_dest_addrs), .cfg_abort(cfg_abort),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .busy(busy),
    .wr_en(wr_en), .rca_sel_w(rca_sel_w), .src_port_sel(src_port_sel),
    .dest_port_sel(dest_port_sel), .src_dest_port(src_dest_port),
    .reg_addr(reg_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected tuple
  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] exp;
    if (rst_n && wr_en) begin
      act = {src_dest_port, (src_dest_port ? dest_port_sel : src_port_sel), rca_sel_w, reg_addr};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got tuple %h, expected no write", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL wr_tuple: got %h, expected %h", act, exp);
        end
      end
    end
  end

  task automatic push_load(input logic [1:0] sel, input logic [9:0] src, input logic [9:0] dest);
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, i[0], sel, src[5*i +: 5]});
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b1, i[0], sel, dest[5*i +: 5]});
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_rca_sel = '0; cfg_src_addrs = '0; cfg_dest_addrs = '0; cfg_abort = 1'b0;
    #1;
    n_checks++;
    if ({cfg_ready, busy, cfg_done, cfg_err, wr_en, rca_sel_w, src_port_sel, dest_port_sel, src_dest_port, reg_addr} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
        {cfg_ready, busy, cfg_done, cfg_err, wr_en, rca_sel_w, src_port_sel, dest_port_sel, src_dest_port, reg_addr});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b busy=%b, expected ready=1 busy=0", cfg_ready, busy);
    end
  endtask

  task automatic test_basic_load;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rca_sel = 2'd1;
    cfg_src_addrs = {5'd3, 5'd7}; cfg_dest_addrs = {5'd9, 5'd12};
    push_load(cfg_rca_sel, cfg_src_addrs, cfg_dest_addrs);
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      n_checks++;
      if (wr_en !== (c <= 4) || cfg_done !== (c == 5) || busy !== (c <= 5) || cfg_ready !== (c == 6)) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: wr_en=%b done=%b busy=%b ready=%b, expected %b %b %b %b",
          c, wr_en, cfg_done, busy, cfg_ready, c <= 4, c == 5, c <= 5, c == 6);
      end
    end
    check_drained("basic");
  endtask

  task automatic test_bad_sel;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rca_sel = 2'd3;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sel_err: err=%b ready=%b wr_en=%b busy=%b, expected 1 1 0 0", cfg_err, cfg_ready, wr_en, busy);
    end
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_sel_pulse: err=%b ready=%b, expected err=0 ready=1", cfg_err, cfg_ready);
    end
    check_drained("bad_sel");
  endtask

  task automatic test_abort;
    logic [9:0] src;
    src = {5'd20, 5'd21};
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rca_sel = 2'd0;
    cfg_src_addrs = src; cfg_dest_addrs = {5'd22, 5'd23};
    exp_q.push_back({1'b0, 1'b0, 2'd0, src[4:0]});
    exp_q.push_back({1'b0, 1'b1, 2'd0, src[9:5]});
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    n_checks++;
    if (wr_en !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0 || cfg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: wr_en=%b ready=%b busy=%b done=%b, expected 0 1 0 0", wr_en, cfg_ready, busy, cfg_done);
    end
    n_checks++;
    if (reg_addr !== 5'd20 || src_port_sel !== 1'b1 || src_dest_port !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold: addr=%0d port=%b sd=%b, expected 20 1 0", reg_addr, src_port_sel, src_dest_port);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (cfg_done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: done=%b, expected 0", cfg_done);
      end
    end
    check_drained("abort");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rca_sel = 2'd2;
    cfg_src_addrs = {5'd1, 5'd2}; cfg_dest_addrs = {5'd3, 5'd4};
    push_load(cfg_rca_sel, cfg_src_addrs, cfg_dest_addrs);
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cfg_rca_sel = 2'd0; cfg_src_addrs = {5'd17, 5'd18}; cfg_dest_addrs = {5'd19, 5'd31};
        push_load(cfg_rca_sel, cfg_src_addrs, cfg_dest_addrs);
      end
      n_checks++;
      if (wr_en !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)) || cfg_done !== (c == 5 || c == 11) ||
          cfg_ready !== (c == 6 || c == 12)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: wr_en=%b done=%b ready=%b", c, wr_en, cfg_done, cfg_ready);
      end
      if (c == 5) cfg_abort = 1'b1;
      if (c == 7) begin
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
      end
    end
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rca_sel = 2'd2;
    cfg_src_addrs = {5'd5, 5'd6}; cfg_dest_addrs = {5'd7, 5'd8};
    exp_q.push_back({1'b0, 1'b0, 2'd2, 5'd6});
    exp_q.push_back({1'b0, 1'b1, 2'd2, 5'd5});
    exp_q.push_back({1'b1, 1'b0, 2'd2, 5'd8});
    @(posedge clk);
    repeat (3) @(negedge clk);
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cfg_ready, busy, cfg_done, cfg_err, wr_en, rca_sel_w, src_port_sel, dest_port_sel, src_dest_port, reg_addr} !== 15'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b, expected all zero",
        {cfg_ready, busy, cfg_done, cfg_err, wr_en, rca_sel_w, src_port_sel, dest_port_sel, src_dest_port, reg_addr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || cfg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: ready=%b busy=%b done=%b, expected 1 0 0", cfg_ready, busy, cfg_done);
    end
    check_drained("rst_mid");
  endtask

  task automatic test_input_change;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rca_sel = 2'd0;
    cfg_src_addrs = {5'd10, 5'd11}; cfg_dest_addrs = {5'd30, 5'd29};
    push_load(cfg_rca_sel, cfg_src_addrs, cfg_dest_addrs);
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_src_addrs = $urandom_range(1023, 0);
      cfg_dest_addrs = $urandom_range(1023, 0);
      cfg_rca_sel = 2'd1;
      n_checks++;
      if (cfg_done !== (c == 5)) begin
        n_fail++;
        $display("FAIL chg_done_cycle%0d: done=%b, expected %b", c, cfg_done, c == 5);
      end
    end
    check_drained("chg");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_sel();
    test_abort();
    test_back_to_back();
    test_reset_mid_load();
    test_input_change();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
